// File: rtl/alu_op_sequencer_if.sv
// ALU drive bus plus result stream between the sequencer and its ALU/consumer.
// Latency: none (wires only).
// Backpressure: res_ready from the consumer stalls the result stream.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             res_valid;
    logic             res_ready;
    logic [SEL_W-1:0] res_sel;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;

    modport master (
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_carry,
        output res_valid, res_sel, res_data, res_carry,
        input  res_ready
    );

    modport slave (
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_carry,
        input  res_valid, res_sel, res_data, res_carry,
        output res_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sweeps opcodes 0..NUM_OPS-1 over one operand pair into a combinational ALU, streams results.
// Latency: sel change -> res_valid in HOLD_CYCLES+1 cycles; define ALU_SIG_EN for the sig port.
// Backpressure: a pending beat and the sweep hold in WAIT until res_ready.
module alu_op_sequencer #(
    parameter int WIDTH       = 16,
    parameter int SEL_W       = 4,
    parameter int NUM_OPS     = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a_in,
    input  logic [WIDTH-1:0] op_b_in,
    alu_op_sequencer_if.master bus,
    output logic             busy,
    output logic             done
`ifdef ALU_SIG_EN
    ,
    output logic [WIDTH-1:0] sig
`endif
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_OPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [SEL_W-1:0] sel_cnt;
    logic [HW-1:0]    hold_cnt;
    logic             load_run;
    logic             do_sample;
    logic             advance;
    logic             xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_run  = 1'b0;
        do_sample = 1'b0;
        advance   = 1'b0;
        // A beat offered in WAIT still counts as transferred if abort lands on the same cycle.
        xfer      = (state == ST_WAIT) && bus.res_valid && bus.res_ready;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        load_run  = 1'b1;
                        state_nxt = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (hold_cnt == '0) state_nxt = ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    do_sample = 1'b1;
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (xfer) begin
                        if (sel_cnt == LAST_SEL) begin
                            state_nxt = ST_DONE;
                        end else begin
                            advance   = 1'b1;
                            state_nxt = ST_DRIVE;
                        end
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            sel_cnt       <= '0;
            hold_cnt      <= '0;
            bus.res_valid <= 1'b0;
            bus.res_sel   <= '0;
            bus.res_data  <= '0;
            bus.res_carry <= 1'b0;
        end else begin
            if (load_run) begin
                bus.alu_a <= op_a_in;
                bus.alu_b <= op_b_in;
                sel_cnt   <= '0;
                hold_cnt  <= HOLD_RELOAD;
            end else if (advance) begin
                sel_cnt  <= sel_cnt + 1'b1;
                hold_cnt <= HOLD_RELOAD;
            end else if (state == ST_DRIVE && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            if (do_sample) begin
                bus.res_valid <= 1'b1;
                bus.res_sel   <= sel_cnt;
                bus.res_data  <= bus.alu_out;
                bus.res_carry <= bus.alu_carry;
            end else if (xfer || abort) begin
                bus.res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SIG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load_run) begin
            sig <= '0;
        end else if (xfer) begin
            sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ bus.res_data
                   ^ {{(WIDTH-1){1'b0}}, bus.res_carry};
        end
    end
`endif

    // Sel is the counter itself, so it keeps its last value across abort and done.
    assign bus.alu_sel = sel_cnt;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: XOR ALU stub, result scoreboard, one task per scenario.
module tb_alu_op_sequencer;
    localparam int W = 16;
    localparam int S = 4;
    localparam int N = 16;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] op_a_in = '0;
    logic [W-1:0] op_b_in = '0;
    logic         busy;
    logic         done;
`ifdef ALU_SIG_EN
    logic [W-1:0] sig;
`endif

    alu_op_sequencer_if #(.WIDTH(W), .SEL_W(S)) bus ();

    assign bus.alu_out   = bus.alu_a ^ bus.alu_b ^ {12'h0, bus.alu_sel};
    assign bus.alu_carry = bus.alu_sel[3];

    alu_op_sequencer #(.WIDTH(W), .SEL_W(S), .NUM_OPS(N), .HOLD_CYCLES(H)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .op_a_in (op_a_in),
        .op_b_in (op_b_in),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
`ifdef ALU_SIG_EN
        ,
        .sig     (sig)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [S-1:0] sel;
        logic [W-1:0] data;
        logic         carry;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [S-1:0] sel);
        beat_t r;
        r.sel   = sel;
        r.data  = a ^ b ^ {12'h0, sel};
        r.carry = sel[3];
        return r;
    endfunction

    task automatic push_sweep(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < N; i++) sb.push_back(model(a, b, S'(i)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
        op_a_in = a;
        op_b_in = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        logic [62:0] outs;
        #2 rst_n = 1'b0;
        tick();
        outs = {busy, done, bus.res_valid, bus.res_carry, bus.res_sel, bus.res_data,
                bus.alu_a, bus.alu_b, bus.alu_sel};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_sweep();
        int    beats = 0;
        int    dones = 0;
        beat_t got, exp, first, last;
        first = '0;
        last  = '0;
        bus.res_ready = 1'b1;
        push_sweep(16'h002A, 16'h00A2);
        go(16'h002A, 16'h00A2);
        for (int c = 0; c < 200; c++) begin
            if (bus.res_valid && bus.res_ready) begin
                got = {bus.res_sel, bus.res_data, bus.res_carry};
                exp = (sb.size() > 0) ? sb.pop_front() : '1;
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL sweep_beat%0d: got %h want %h", beats, got, exp);
                end
                if (beats == 0) first = got;
                last = got;
                beats++;
            end
            if (done) dones++;
            if (dones > 0 && !busy) break;
            tick();
        end
        vectors++;
        if (first.data !== 16'h0088 || first.sel !== 4'h0) begin
            miscompares++;
            $display("FAIL sweep_first: got sel %h data %h want 0 0088", first.sel, first.data);
        end
        vectors++;
        if (last.data !== 16'h0087 || last.sel !== 4'hF || last.carry !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_last: got %h want sel F data 0087 carry 1", last);
        end
        vectors++;
        if (beats != N || dones != 1 || busy !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL sweep_end: beats=%0d dones=%0d busy=%b left=%0d want 16 1 0 0",
                     beats, dones, busy, sb.size());
        end
    endtask

    task automatic test_latency();
        logic [S-1:0] prev;
        logic         pv = 1'b0;
        int           cnt = 0;
        int           seen = 0;
        bus.res_ready = 1'b1;
        go(16'h1111, 16'h0F0F);
        prev = bus.alu_sel;
        for (int c = 0; c < 200; c++) begin
            tick();
            cnt++;
            if (bus.alu_sel !== prev) cnt = 0;
            prev = bus.alu_sel;
            if (bus.res_valid && !pv) begin
                seen++;
                vectors++;
                if (cnt != H + 1) begin
                    miscompares++;
                    $display("FAIL latency_sel%0h: got %0d cycles want %0d", bus.res_sel, cnt, H + 1);
                end
            end
            pv = bus.res_valid;
            if (done) break;
        end
        tick();
        vectors++;
        if (seen != N || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_count: got %0d beats busy=%b want %0d 0", seen, busy, N);
        end
    endtask

    task automatic test_backpressure();
        int    beats = 0;
        int    dones = 0;
        bit    stalled = 1'b0;
        beat_t got, exp, held;
        bus.res_ready = 1'b1;
        push_sweep(16'h002A, 16'h00A2);
        go(16'h002A, 16'h00A2);
        for (int c = 0; c < 300; c++) begin
            if (bus.res_valid && bus.res_sel == 4'h3 && !stalled) begin
                bus.res_ready = 1'b0;
                held = {bus.res_sel, bus.res_data, bus.res_carry};
                for (int k = 0; k < 10; k++) begin
                    tick();
                    got = {bus.res_sel, bus.res_data, bus.res_carry};
                    vectors++;
                    if (bus.res_valid !== 1'b1 || got !== held || bus.alu_sel !== 4'h3) begin
                        miscompares++;
                        $display("FAIL stall_hold%0d: valid=%b beat=%h sel=%h want 1 %h 3",
                                 k, bus.res_valid, got, held, bus.alu_sel);
                    end
                end
                bus.res_ready = 1'b1;
                stalled = 1'b1;
            end
            if (bus.res_valid && bus.res_ready) begin
                got = {bus.res_sel, bus.res_data, bus.res_carry};
                exp = (sb.size() > 0) ? sb.pop_front() : '1;
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL stall_beat%0d: got %h want %h", beats, got, exp);
                end
                beats++;
            end
            if (done) dones++;
            if (dones > 0 && !busy) break;
            tick();
        end
        vectors++;
        if (beats != N || dones != 1 || sb.size() != 0 || !stalled) begin
            miscompares++;
            $display("FAIL stall_end: beats=%0d dones=%0d left=%0d stalled=%b want 16 1 0 1",
                     beats, dones, sb.size(), stalled);
        end
    endtask

    task automatic test_abort();
        int    dones = 0;
        bit    hit = 1'b0;
        beat_t got, exp;
        bus.res_ready = 1'b1;
        push_sweep(16'hBEEF, 16'h1234);
        go(16'hBEEF, 16'h1234);
        for (int c = 0; c < 200 && !hit; c++) begin
            if (bus.res_valid && bus.res_ready) begin
                got = {bus.res_sel, bus.res_data, bus.res_carry};
                exp = (sb.size() > 0) ? sb.pop_front() : '1;
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL abort_beat: got %h want %h", got, exp);
                end
                if (bus.res_sel == 4'h7) begin
                    abort = 1'b1;
                    hit   = 1'b1;
                end
            end
            tick();
            abort = 1'b0;
        end
        vectors++;
        if (!hit || busy !== 1'b0 || bus.res_valid !== 1'b0 || done !== 1'b0 || bus.alu_sel !== 4'h7) begin
            miscompares++;
            $display("FAIL abort_idle: hit=%b busy=%b valid=%b done=%b sel=%h want 1 0 0 0 7",
                     hit, busy, bus.res_valid, done, bus.alu_sel);
        end
        for (int k = 0; k < 8; k++) begin
            if (done) dones++;
            tick();
        end
        vectors++;
        if (dones != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_nodone: dones=%0d busy=%b want 0 0", dones, busy);
        end
        sb.delete();
        go(16'h0F00, 16'h00F0);
        for (int c = 0; c < 20 && !bus.res_valid; c++) tick();
        got = {bus.res_sel, bus.res_data, bus.res_carry};
        exp = model(16'h0F00, 16'h00F0, 4'h0);
        vectors++;
        if (bus.res_valid !== 1'b1 || got !== exp) begin
            miscompares++;
            $display("FAIL abort_restart: valid=%b got %h want 1 %h", bus.res_valid, got, exp);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_ignored();
        logic [62:0] outs;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_abort_idle: busy=%b want 0", busy);
        end
        bus.res_ready = 1'b0;
        go(16'h1234, 16'h5678);
        for (int c = 0; c < 20 && !bus.res_valid; c++) tick();
        op_a_in = 16'hFFFF;
        op_b_in = 16'hFFFF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        vectors++;
        if (bus.alu_a !== 16'h1234 || bus.alu_b !== 16'h5678 || bus.alu_sel !== 4'h0 ||
            bus.res_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_while_busy: a=%h b=%h sel=%h valid=%b busy=%b want 1234 5678 0 1 1",
                     bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_valid, busy);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        outs = {busy, done, bus.res_valid, bus.res_carry, bus.res_sel, bus.res_data,
                bus.alu_a, bus.alu_b, bus.alu_sel};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 0", outs);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

`ifdef ALU_SIG_EN
    task automatic test_sig();
        logic [W-1:0] ms = '0;
        bus.res_ready = 1'b1;
        go(16'h002A, 16'h00A2);
        vectors++;
        if (sig !== '0) begin
            miscompares++;
            $display("FAIL sig_clear: got %h want 0", sig);
        end
        for (int c = 0; c < 200; c++) begin
            if (bus.res_valid && bus.res_ready)
                ms = {ms[W-2:0], ms[W-1]} ^ bus.res_data ^ {{(W-1){1'b0}}, bus.res_carry};
            if (done) break;
            tick();
        end
        tick();
        tick();
        vectors++;
        if (sig !== ms || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sig_final: got %h busy=%b want %h 0", sig, busy, ms);
        end
    endtask
`endif

    initial begin
        bus.res_ready = 1'b0;
        test_reset();
        test_sweep();
        test_latency();
        test_backpressure();
        test_abort();
        test_ignored();
`ifdef ALU_SIG_EN
        test_sig();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
